// File: rtl/ceres_param.sv
// Shared fetch-path types and constants.
package ceres_param;

    typedef enum logic {ALN_EMPTY, ALN_HALF} align_state_e;

    localparam logic [1:0] OPC_UNCOMPRESSED = 2'b11;

    function automatic logic is_comp(input logic [15:0] parcel);
        return parcel[1:0] != OPC_UNCOMPRESSED;
    endfunction

endpackage

// File: rtl/fetch_instr_aligner.sv
// Re-aligns a sequential 32-bit fetch word stream into whole RV32IC
// instructions, one per handshake, using a one-halfword residual buffer.
//
// state     | meaning
// ALN_EMPTY | no residual parcel; next parcel is the low half of the fetch word
// ALN_HALF  | res holds the next parcel (from the upper half of the last word)
module fetch_instr_aligner
    import ceres_param::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_data_i,
    input  logic        fetch_err_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_is_comp_o,
    output logic        instr_err_o
);

    align_state_e state, state_next;
    logic [31:0]  pc, pc_next;
    logic [15:0]  res, res_next;
    logic         res_err, res_err_next;
    logic         skip_low, skip_low_next;
    logic         fire;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ALN_EMPTY;
            pc       <= RESET_PC & ~32'h1;
            skip_low <= RESET_PC[1];
            res      <= '0;
            res_err  <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            skip_low <= skip_low_next;
            res      <= res_next;
            res_err  <= res_err_next;
        end
    end

    assign fire = instr_valid_o && instr_ready_i;

    always_comb begin
        instr_valid_o = 1'b0;
        fetch_ready_o = 1'b0;
        instr_o       = '0;
        instr_err_o   = 1'b0;
        state_next    = state;
        pc_next       = pc;
        res_next      = res;
        res_err_next  = res_err;
        skip_low_next = skip_low;

        if (flush_i) begin
            // Redirect wins over any handshake that would otherwise occur.
            state_next    = ALN_EMPTY;
            pc_next       = flush_pc_i & ~32'h1;
            skip_low_next = flush_pc_i[1];
            res_err_next  = 1'b0;
        end else if (!rst_i) begin
            unique case (state)
                ALN_EMPTY: begin
                    if (skip_low) begin
                        // Absorb cycle: the low parcel precedes the target PC.
                        fetch_ready_o = fetch_valid_i;
                        if (fetch_valid_i) begin
                            res_next      = fetch_data_i[31:16];
                            res_err_next  = fetch_err_i;
                            skip_low_next = 1'b0;
                            state_next    = ALN_HALF;
                        end
                    end else if (fetch_valid_i) begin
                        instr_valid_o = 1'b1;
                        instr_err_o   = fetch_err_i;
                        fetch_ready_o = instr_ready_i;
                        if (is_comp(fetch_data_i[15:0])) begin
                            instr_o = {16'h0, fetch_data_i[15:0]};
                            if (fire) begin
                                res_next     = fetch_data_i[31:16];
                                res_err_next = fetch_err_i;
                                pc_next      = pc + 32'd2;
                                state_next   = ALN_HALF;
                            end
                        end else begin
                            instr_o = fetch_data_i;
                            if (fire) pc_next = pc + 32'd4;
                        end
                    end
                end
                ALN_HALF: begin
                    if (is_comp(res)) begin
                        instr_valid_o = 1'b1;
                        instr_o       = {16'h0, res};
                        instr_err_o   = res_err;
                        if (fire) begin
                            pc_next    = pc + 32'd2;
                            state_next = ALN_EMPTY;
                        end
                    end else if (fetch_valid_i) begin
                        instr_valid_o = 1'b1;
                        instr_o       = {fetch_data_i[15:0], res};
                        instr_err_o   = res_err | fetch_err_i;
                        fetch_ready_o = instr_ready_i;
                        if (fire) begin
                            res_next     = fetch_data_i[31:16];
                            res_err_next = fetch_err_i;
                            pc_next      = pc + 32'd4;
                        end
                    end
                end
                default: state_next = ALN_EMPTY;
            endcase
        end
    end

    assign instr_pc_o      = pc;
    assign instr_is_comp_o = is_comp(instr_o[15:0]);

endmodule

// File: tb/tb_fetch_instr_aligner.sv
// Directed bench for fetch_instr_aligner with hand-computed expectations.
module tb_fetch_instr_aligner;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic [31:0] fetch_data_i = '0;
    logic        fetch_err_i = 1'b0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_is_comp_o;
    logic        instr_err_o;

    int passed = 0;
    int total  = 0;

    fetch_instr_aligner dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
        .fetch_data_i(fetch_data_i), .fetch_err_i(fetch_err_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_is_comp_o(instr_is_comp_o), .instr_err_o(instr_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Apply inputs on the falling edge, settle, then the caller checks.
    task automatic drive(input logic fl, input logic [31:0] fpc, input logic fv,
                         input logic [31:0] fd, input logic fe, input logic ir);
        @(negedge clk_i);
        flush_i = fl; flush_pc_i = fpc; fetch_valid_i = fv;
        fetch_data_i = fd; fetch_err_i = fe; instr_ready_i = ir;
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0013, 1'b0, 1'b1);
        @(posedge clk_i);
        #1;
        total++; if (instr_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", instr_valid_o); else passed++;
        total++; if (fetch_ready_o !== 1'b0) $display("FAIL reset_fready got %b want 0", fetch_ready_o); else passed++;
        total++; if (instr_o !== 32'h0) $display("FAIL reset_instr got %h want 0", instr_o); else passed++;
        total++; if (instr_pc_o !== 32'h8000_0000) $display("FAIL reset_pc got %h want 80000000", instr_pc_o); else passed++;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        rst_i = 1'b0;
        #1;
        total++; if (instr_valid_o !== 1'b0) $display("FAIL idle_valid got %b want 0", instr_valid_o); else passed++;
    endtask

    task automatic test_aligned();
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0013, 1'b0, 1'b1);
        total++; if (instr_o !== 32'h0000_0013) $display("FAIL aligned_instr got %h want 00000013", instr_o); else passed++;
        total++; if (instr_pc_o !== 32'h8000_0000) $display("FAIL aligned_pc got %h want 80000000", instr_pc_o); else passed++;
        total++; if (instr_is_comp_o !== 1'b0) $display("FAIL aligned_comp got %b want 0", instr_is_comp_o); else passed++;
        total++; if (fetch_ready_o !== 1'b1 || instr_valid_o !== 1'b1)
            $display("FAIL aligned_hs got rdy=%b vld=%b want 1 1", fetch_ready_o, instr_valid_o); else passed++;
        @(posedge clk_i);
    endtask

    task automatic test_two_comp();
        drive(1'b0, 32'h0, 1'b1, 32'h4501_4505, 1'b0, 1'b1);
        total++; if (instr_o !== 32'h0000_4505 || instr_pc_o !== 32'h8000_0004)
            $display("FAIL comp0 got %h@%h want 00004505@80000004", instr_o, instr_pc_o); else passed++;
        total++; if (instr_is_comp_o !== 1'b1 || fetch_ready_o !== 1'b1)
            $display("FAIL comp0_flags got comp=%b rdy=%b want 1 1", instr_is_comp_o, fetch_ready_o); else passed++;
        @(posedge clk_i);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        total++; if (instr_o !== 32'h0000_4501 || instr_pc_o !== 32'h8000_0006 || instr_valid_o !== 1'b1)
            $display("FAIL comp1 got %h@%h v=%b want 00004501@80000006 v=1", instr_o, instr_pc_o, instr_valid_o); else passed++;
        total++; if (fetch_ready_o !== 1'b0) $display("FAIL comp1_fready got %b want 0", fetch_ready_o); else passed++;
        @(posedge clk_i);
    endtask

    task automatic test_straddle();
        drive(1'b0, 32'h0, 1'b1, 32'h0013_4505, 1'b0, 1'b1);
        total++; if (instr_o !== 32'h0000_4505 || instr_pc_o !== 32'h8000_0008)
            $display("FAIL strad0 got %h@%h want 00004505@80000008", instr_o, instr_pc_o); else passed++;
        @(posedge clk_i);
        drive(1'b0, 32'h0, 1'b1, 32'h4505_0000, 1'b0, 1'b1);
        total++; if (instr_o !== 32'h0000_0013 || instr_pc_o !== 32'h8000_000A)
            $display("FAIL strad1 got %h@%h want 00000013@8000000a", instr_o, instr_pc_o); else passed++;
        total++; if (fetch_ready_o !== 1'b1 || instr_is_comp_o !== 1'b0)
            $display("FAIL strad1_flags got rdy=%b comp=%b want 1 0", fetch_ready_o, instr_is_comp_o); else passed++;
        @(posedge clk_i);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        total++; if (instr_o !== 32'h0000_4505 || instr_pc_o !== 32'h8000_000E || fetch_ready_o !== 1'b0)
            $display("FAIL strad2 got %h@%h rdy=%b want 00004505@8000000e rdy=0", instr_o, instr_pc_o, fetch_ready_o); else passed++;
        @(posedge clk_i);
    endtask

    task automatic test_backpressure();
        drive(1'b0, 32'h0, 1'b1, 32'h0013_4505, 1'b0, 1'b1);
        @(posedge clk_i);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 32'h4501_0000, 1'b0, 1'b0);
            total++; if (instr_valid_o !== 1'b1 || fetch_ready_o !== 1'b0 || instr_o !== 32'h0000_0013 || instr_pc_o !== 32'h8000_0012)
                $display("FAIL bp_hold%0d got v=%b rdy=%b %h@%h want v=1 rdy=0 00000013@80000012",
                         i, instr_valid_o, fetch_ready_o, instr_o, instr_pc_o); else passed++;
            @(posedge clk_i);
        end
        drive(1'b0, 32'h0, 1'b1, 32'h4501_0000, 1'b0, 1'b1);
        total++; if (fetch_ready_o !== 1'b1 || instr_o !== 32'h0000_0013)
            $display("FAIL bp_release got rdy=%b %h want rdy=1 00000013", fetch_ready_o, instr_o); else passed++;
        @(posedge clk_i);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        total++; if (instr_o !== 32'h0000_4501 || instr_pc_o !== 32'h8000_0016)
            $display("FAIL bp_after got %h@%h want 00004501@80000016", instr_o, instr_pc_o); else passed++;
        @(posedge clk_i);
    endtask

    task automatic test_fault();
        drive(1'b0, 32'h0, 1'b1, 32'h0013_4505, 1'b0, 1'b1);
        total++; if (instr_err_o !== 1'b0 || instr_pc_o !== 32'h8000_0018)
            $display("FAIL fault0 got err=%b pc=%h want 0 80000018", instr_err_o, instr_pc_o); else passed++;
        @(posedge clk_i);
        drive(1'b0, 32'h0, 1'b1, 32'h4505_0000, 1'b1, 1'b1);
        total++; if (instr_err_o !== 1'b1 || instr_o !== 32'h0000_0013)
            $display("FAIL fault_strad got err=%b %h want 1 00000013", instr_err_o, instr_o); else passed++;
        @(posedge clk_i);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        total++; if (instr_err_o !== 1'b1 || instr_o !== 32'h0000_4505 || instr_pc_o !== 32'h8000_001E)
            $display("FAIL fault_res got err=%b %h@%h want 1 00004505@8000001e", instr_err_o, instr_o, instr_pc_o); else passed++;
        @(posedge clk_i);
    endtask

    task automatic test_flush_odd();
        drive(1'b1, 32'h8000_0102, 1'b1, 32'h4501_0000, 1'b0, 1'b1);
        total++; if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b0)
            $display("FAIL flush_cycle got v=%b rdy=%b want 0 0", instr_valid_o, fetch_ready_o); else passed++;
        @(posedge clk_i);
        drive(1'b0, 32'h0, 1'b1, 32'h4501_0000, 1'b0, 1'b1);
        total++; if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b1)
            $display("FAIL absorb got v=%b rdy=%b want 0 1", instr_valid_o, fetch_ready_o); else passed++;
        @(posedge clk_i);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        total++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h0000_4501 || instr_pc_o !== 32'h8000_0102)
            $display("FAIL odd_target got v=%b %h@%h want 1 00004501@80000102", instr_valid_o, instr_o, instr_pc_o); else passed++;
        @(posedge clk_i);
    endtask

    task automatic test_flush_pending();
        drive(1'b1, 32'h8000_0200, 1'b1, 32'h0000_0013, 1'b0, 1'b1);
        total++; if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b0)
            $display("FAIL flush_hs got v=%b rdy=%b want 0 0", instr_valid_o, fetch_ready_o); else passed++;
        @(posedge clk_i);
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0013, 1'b0, 1'b1);
        total++; if (instr_o !== 32'h0000_0013 || instr_pc_o !== 32'h8000_0200 || fetch_ready_o !== 1'b1)
            $display("FAIL flush_restart got %h@%h rdy=%b want 00000013@80000200 rdy=1", instr_o, instr_pc_o, fetch_ready_o); else passed++;
        @(posedge clk_i);
    endtask

    task automatic test_wrap();
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b1);
        @(posedge clk_i);
        drive(1'b0, 32'h0, 1'b1, 32'h4501_4505, 1'b0, 1'b1);
        total++; if (instr_o !== 32'h0000_4505 || instr_pc_o !== 32'hFFFF_FFFC)
            $display("FAIL wrap0 got %h@%h want 00004505@fffffffc", instr_o, instr_pc_o); else passed++;
        @(posedge clk_i);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        total++; if (instr_o !== 32'h0000_4501 || instr_pc_o !== 32'hFFFF_FFFE)
            $display("FAIL wrap1 got %h@%h want 00004501@fffffffe", instr_o, instr_pc_o); else passed++;
        @(posedge clk_i);
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0013, 1'b0, 1'b1);
        total++; if (instr_o !== 32'h0000_0013 || instr_pc_o !== 32'h0000_0000)
            $display("FAIL wrap2 got %h@%h want 00000013@00000000", instr_o, instr_pc_o); else passed++;
        @(posedge clk_i);
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_two_comp();
        test_straddle();
        test_backpressure();
        test_fault();
        test_flush_odd();
        test_flush_pending();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
